event_sequence_trigger: RTL

//  Hardware counterpart of a "wait(level); @(posedge strobe); @(event)" sequence, placed upstream of
//  the always/@/event/wait demo stage: synchronises a level and a strobe, detects changes/edges,

---
 rtl/event_sequence_trigger.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/event_sequence_trigger.sv
// Synchronises a level and a strobe, then walks an armed FSM through level -> rising edge -> event,
// pulsing 'arrived' on completion or 'timed_out' when a wait state overstays. Keeps debug counters.
module event_sequence_trigger #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             clr_counts,
    input  logic             level_in,
    input  logic             edge_in,
    input  logic             event_in,
    output logic             level_q,
    output logic             change_pulse,
    output logic             rise_pulse,
    output logic [2:0]       state,
    output logic             busy,
    output logic             arrived,
    output logic             timed_out,
    output logic [CNT_W-1:0] change_count,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] event_count
);

    localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitLevel = 3'd1,
        StWaitEdge  = 3'd2,
        StWaitEvent = 3'd3,
        StDone      = 3'd4,
        StTimeout   = 3'd5
    } state_e;

    logic [SYNC_STAGES-1:0] level_sync_q;
    logic [SYNC_STAGES-1:0] edge_sync_q;
    logic                   level_prev_q;
    logic                   edge_prev_q;
    logic                   edge_s;

    state_e            st_q, st_d, adv_st;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              advance;

    assign level_q = level_sync_q[SYNC_STAGES-1];
    assign edge_s  = edge_sync_q[SYNC_STAGES-1];
    assign state   = st_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_sync_q <= '0;
            edge_sync_q  <= '0;
            level_prev_q <= 1'b0;
            edge_prev_q  <= 1'b0;
            change_pulse <= 1'b0;
            rise_pulse   <= 1'b0;
        end else begin
            level_sync_q <= {level_sync_q[SYNC_STAGES-2:0], level_in};
            edge_sync_q  <= {edge_sync_q[SYNC_STAGES-2:0], edge_in};
            level_prev_q <= level_q;
            edge_prev_q  <= edge_s;
            change_pulse <= level_q ^ level_prev_q;
            rise_pulse   <= edge_s & ~edge_prev_q;
        end
    end

    always_comb begin
        advance = 1'b0;
        adv_st  = StIdle;
        case (st_q)
            StWaitLevel: begin advance = level_q;    adv_st = StWaitEdge;  end
            StWaitEdge:  begin advance = rise_pulse; adv_st = StWaitEvent; end
            StWaitEvent: begin advance = event_in;   adv_st = StDone;      end
            default:     begin advance = 1'b0;       adv_st = StIdle;      end
        endcase
    end

    // Advance beats expiry when both land on the last timer cycle.
    always_comb begin
        st_d    = st_q;
        timer_d = timer_q;
        if (abort) begin
            st_d    = StIdle;
            timer_d = '0;
        end else begin
            case (st_q)
                StIdle: begin
                    timer_d = '0;
                    if (arm) st_d = StWaitLevel;
                end
                StWaitLevel, StWaitEdge, StWaitEvent: begin
                    if (advance) begin
                        st_d    = adv_st;
                        timer_d = '0;
                    end else if (timer_q == TimerLast) begin
                        st_d    = StTimeout;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                default: begin
                    st_d    = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q      <= StIdle;
            timer_q   <= '0;
            busy      <= 1'b0;
            arrived   <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            st_q      <= st_d;
            timer_q   <= timer_d;
            busy      <= st_d inside {StWaitLevel, StWaitEdge, StWaitEvent};
            arrived   <= (st_d == StDone);
            timed_out <= (st_d == StTimeout);
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        return (inc && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || clr_counts) begin
            change_count <= '0;
            edge_count   <= '0;
            event_count  <= '0;
        end else begin
            change_count <= sat_inc(change_count, change_pulse);
            edge_count   <= sat_inc(edge_count, rise_pulse);
            event_count  <= sat_inc(event_count, event_in);
        end
    end

endmodule
